// File: rtl/i3c_sta_sto_gen.sv
// I3C line sequencer: drives SCL/SDA for START, Repeated START and STOP.
// Hands start/stop pattern flags to the bus timer and waits on its CAS indication.
module i3c_sta_sto_gen #(
  parameter logic [23:0] HALF_PER    = 24'd2,
  parameter logic [23:0] T_CBP       = 24'd1,
  parameter logic [23:0] CAS_TIMEOUT = 24'd2500001
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start_req,
  input  logic i_rstart_req,
  input  logic i_stop_req,
  input  logic i_timer_cas,
  input  logic i_timer_bus_free_pure,
  output logic o_scl,
  output logic o_sda,
  output logic o_start_pattern,
  output logic o_stop_pattern,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);

  localparam int unsigned CNT_W = 24;

  typedef enum logic [3:0] {
    IDLE,
    STA_WAIT_FREE,
    RS_SDA_HI,
    RS_SCL_HI,
    SDA_FALL,
    WAIT_CAS,
    SCL_FALL,
    STO_SDA_LO,
    STO_SCL_HI,
    STO_SDA_HI
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             bus_free_seen;

  logic free_now;
  logic half_end;
  logic cbp_end;
  logic cas_tmo;

  // A free indication on the current cycle counts, so SDA can fall on the very next cycle.
  assign free_now = bus_free_seen | i_timer_bus_free_pure;
  assign half_end = (cnt == (HALF_PER - CNT_W'(1)));
  assign cbp_end  = (cnt == (T_CBP - CNT_W'(1)));
  assign cas_tmo  = (cnt == (CAS_TIMEOUT - CNT_W'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      bus_free_seen   <= 1'b1;
      o_scl           <= 1'b1;
      o_sda           <= 1'b1;
      o_start_pattern <= 1'b0;
      o_stop_pattern  <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_start_pattern <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
      cnt             <= cnt + CNT_W'(1);
      if (i_timer_bus_free_pure) bus_free_seen <= 1'b1;

      unique case (state)
        // The o_done cycle of a START still reads busy, so requests wait one more cycle.
        IDLE: begin
          cnt <= '0;
          if (o_busy) begin
            o_busy <= 1'b0;
          end else if (i_stop_req) begin
            if (o_scl) begin
              o_err <= 1'b1;
            end else begin
              state  <= STO_SDA_LO;
              o_sda  <= 1'b0;
              o_busy <= 1'b1;
            end
          end else if (i_rstart_req) begin
            if (o_scl) begin
              o_err <= 1'b1;
            end else begin
              state  <= RS_SDA_HI;
              o_sda  <= 1'b1;
              o_busy <= 1'b1;
            end
          end else if (i_start_req) begin
            if (!o_scl) begin
              o_err <= 1'b1;
            end else begin
              state  <= STA_WAIT_FREE;
              o_busy <= 1'b1;
            end
          end
        end

        STA_WAIT_FREE: begin
          cnt <= '0;
          if (free_now) begin
            state           <= SDA_FALL;
            o_sda           <= 1'b0;
            o_start_pattern <= 1'b1;
            o_stop_pattern  <= 1'b0;
            bus_free_seen   <= 1'b0;
          end
        end

        RS_SDA_HI: begin
          if (half_end) begin
            state <= RS_SCL_HI;
            o_scl <= 1'b1;
            cnt   <= '0;
          end
        end

        RS_SCL_HI: begin
          if (half_end) begin
            state           <= SDA_FALL;
            o_sda           <= 1'b0;
            o_start_pattern <= 1'b1;
            o_stop_pattern  <= 1'b0;
            bus_free_seen   <= 1'b0;
            cnt             <= '0;
          end
        end

        SDA_FALL: begin
          state <= WAIT_CAS;
          cnt   <= '0;
        end

        // A CAS arriving on the last allowed cycle wins over the timeout.
        WAIT_CAS: begin
          if (i_timer_cas) begin
            state <= SCL_FALL;
            o_scl <= 1'b0;
            cnt   <= '0;
          end else if (cas_tmo) begin
            state <= SCL_FALL;
            o_scl <= 1'b0;
            o_err <= 1'b1;
            cnt   <= '0;
          end
        end

        SCL_FALL: begin
          if (half_end) begin
            state  <= IDLE;
            o_done <= 1'b1;
            cnt    <= '0;
          end
        end

        STO_SDA_LO: begin
          if (half_end) begin
            state <= STO_SCL_HI;
            o_scl <= 1'b1;
            cnt   <= '0;
          end
        end

        STO_SCL_HI: begin
          if (cbp_end) begin
            state          <= STO_SDA_HI;
            o_sda          <= 1'b1;
            o_stop_pattern <= 1'b1;
            o_done         <= 1'b1;
            cnt            <= '0;
          end
        end

        STO_SDA_HI: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          cnt    <= '0;
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
